nv_nvdla_csb2apb: RTL and testbench
===================================

NV_NVDLA_CSB2APB -- requirements
Module: nv_nvdla_csb2apb

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000: APB byte-address base added to every CSB word address.
REQ-002 SHALL have parameter TIMEOUT, default 255: maximum ACCESS cycles waiting for pready; 0 disables the timeout.
REQ-003 SHALL use one clock and a synchronous, active-high reset; all state changes on the rising edge of pclk.
REQ-004 pclk  in  1  clock.
REQ-005 prst  in  1  synchronous active-high reset.
REQ-006 csb2nvdla_valid  in  1  CSB request valid.
REQ-007 csb2nvdla_ready  out  1  CSB request accepted when high together with valid.
REQ-008 csb2nvdla_addr  in  16  CSB word address.
REQ-009 csb2nvdla_wdat  in  32  write data.
REQ-010 csb2nvdla_write  in  1  1 = write, 0 = read.
REQ-011 csb2nvdla_nposted  in  1  write needs a completion response.
REQ-012 nvdla2csb_valid  out  1  one-cycle read-data pulse.
REQ-013 nvdla2csb_data  out  32  read data, valid with nvdla2csb_valid.
REQ-014 nvdla2csb_wr_complete  out  1  one-cycle non-posted write completion pulse.
REQ-015 psel, penable, pwrite  out  1 each  APB master control.
REQ-016 paddr  out  32 / pwdata  out  32  APB address and write data.
REQ-017 prdata  in  32 / pready  in  1 / pslverr  in  1  APB completer response.
REQ-018 apb_err  out  1  one-cycle pulse on pslverr or timeout.

Function
REQ-019 SHALL implement the FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
REQ-020 csb2nvdla_ready SHALL be 1 only in IDLE; a handshake in IDLE captures addr, wdat, write and nposted, and moves to SETUP.
REQ-021 paddr SHALL be BASE_ADDR + {csb2nvdla_addr, 2'b00}, computed modulo 2^32 (wrap allowed).
REQ-022 SETUP: psel=1, penable=0, one cycle only; ACCESS: psel=1, penable=1, held until pready=1 or timeout.
REQ-023 paddr, pwrite and pwdata SHALL stay stable from SETUP through the last ACCESS cycle; pwdata SHALL be 0 for reads.
REQ-024 On pready=1 in ACCESS, the FSM SHALL capture prdata and pslverr, drop psel and penable, and go to RESP.
REQ-025 RESP, one cycle, for a read: nvdla2csb_valid=1; data = captured prdata, or 32'h0 if pslverr was 1.
REQ-026 RESP for a non-posted write: nvdla2csb_wr_complete=1; for a posted write: no response pulse.
REQ-027 apb_err SHALL pulse in RESP when pslverr was captured as 1 or a timeout occurred.
REQ-028 A timeout SHALL trigger when the count of ACCESS cycles without pready reaches TIMEOUT (TIMEOUT != 0). It SHALL drop psel and go to RESP with read data 32'hFFFF_FFFF and apb_err=1.
REQ-029 Minimum latency: handshake at cycle N, SETUP at N+1, ACCESS with pready at N+2, response pulse at N+3, ready again at N+4.
REQ-030 Exactly one transaction SHALL be outstanding; csb2nvdla_valid outside IDLE SHALL be ignored.
REQ-031 pready or pslverr outside ACCESS SHALL be ignored.

Reset
REQ-032 While prst=1 every output SHALL be 0 except csb2nvdla_ready; the FSM SHALL be in IDLE and the timeout counter 0.
REQ-033 csb2nvdla_ready SHALL be 1 in the cycle after reset is released.
REQ-034 Reset during any state SHALL abort the transfer next edge (psel=0) and discard the pending response.

Structure
REQ-035 A shared package nv_nvdla_csb2apb_pkg SHALL hold the FSM state enum, TIMEOUT_RDATA (32'hFFFF_FFFF) and ERR_RDATA (32'h0).
REQ-036 The timeout counter SHALL be the sub-module nv_nvdla_csb2apb_tmo. Its inputs are clear, enable and limit; its output is expired. Its width is clog2(TIMEOUT+1).

Verification
REQ-037 Read addr 16'h0010, BASE_ADDR 32'h1000_0000, pready at first ACCESS, prdata 32'hCAFE_0001 -> paddr 32'h1000_0040; nvdla2csb_valid at N+3 with 32'hCAFE_0001.
REQ-038 Non-posted write addr 16'h0004, wdat 32'h1234_5678, pready after 3 wait cycles -> pwdata stable for 4 ACCESS cycles; wr_complete pulses once; no nvdla2csb_valid.
REQ-039 Posted write -> no response pulses; ready returns 1 at N+4.
REQ-040 Read with pslverr=1 -> data 32'h0 and apb_err pulse; TIMEOUT=4 with pready never set -> 4 ACCESS cycles, data 32'hFFFF_FFFF, apb_err=1.
REQ-041 Reset asserted in ACCESS -> psel=0 next cycle; no response pulse; ready=1 after release.
REQ-042 addr 16'hFFFF with BASE_ADDR 32'hFFFF_FFF0 -> paddr 32'h0003_FFEC (wrap).

Source files
------------

// File: rtl/nv_nvdla_csb2apb_pkg.sv
// Shared types and constants for the CSB-to-APB bridge.
// Holds the FSM state encoding, the fixed error read-data values and address helpers.
package nv_nvdla_csb2apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    localparam logic [31:0] TIMEOUT_RDATA = 32'hFFFF_FFFF;
    localparam logic [31:0] ERR_RDATA     = 32'h0000_0000;

    // CSB addresses are 32-bit word addresses; APB wants bytes. Wraps modulo 2^32.
    function automatic logic [31:0] csb_to_apb_addr(input logic [31:0] base,
                                                    input logic [15:0] word_addr);
        return base + {14'd0, word_addr, 2'b00};
    endfunction

    // Counter width for a given limit; a disabled timeout still needs a 1-bit port.
    function automatic int tmo_width(input int limit);
        return (limit > 0) ? $clog2(limit + 1) : 1;
    endfunction

endpackage

// File: rtl/nv_nvdla_csb2apb_tmo.sv
// ACCESS-phase wait counter: counts enabled cycles and flags the one that reaches the limit.
// A limit of zero never expires.
module nv_nvdla_csb2apb_tmo
    import nv_nvdla_csb2apb_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clear,
    input  logic         i_enable,
    input  logic [W-1:0] i_limit,
    output logic         o_expired
);

    logic [W-1:0] r_count;
    logic [W:0]   w_next;

    assign w_next    = {1'b0, r_count} + {{W{1'b0}}, 1'b1};
    // Expiry is seen in the same cycle as the limit-th stalled cycle so the FSM leaves on time.
    assign o_expired = i_enable && (i_limit != '0) && (w_next == {1'b0, i_limit});

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= w_next[W-1:0];
        end
    end

endmodule

// File: rtl/nv_nvdla_csb2apb.sv
// CSB slave to APB master bridge: one outstanding transfer, optional ACCESS-phase timeout,
// read-data / non-posted write completion pulses and an error pulse on pslverr or timeout.
module nv_nvdla_csb2apb
    import nv_nvdla_csb2apb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          TIMEOUT   = 255
) (
    input  logic        pclk,
    input  logic        prst,
    input  logic        csb2nvdla_valid,
    output logic        csb2nvdla_ready,
    input  logic [15:0] csb2nvdla_addr,
    input  logic [31:0] csb2nvdla_wdat,
    input  logic        csb2nvdla_write,
    input  logic        csb2nvdla_nposted,
    output logic        nvdla2csb_valid,
    output logic [31:0] nvdla2csb_data,
    output logic        nvdla2csb_wr_complete,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        pslverr,
    output logic        apb_err
);

    localparam int                TMO_W     = tmo_width(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT);

    state_e      r_state;
    state_e      w_next_state;

    logic [31:0] r_paddr;
    logic [31:0] r_pwdata;
    logic        r_pwrite;
    logic        r_nposted;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_handshake;
    logic        w_tmo_clear;
    logic        w_tmo_enable;
    logic        w_tmo_expired;

    assign w_handshake  = csb2nvdla_valid && (r_state == ST_IDLE);
    assign w_tmo_clear  = (r_state != ST_ACCESS);
    assign w_tmo_enable = (r_state == ST_ACCESS) && !pready;

    nv_nvdla_csb2apb_tmo #(
        .W (TMO_W)
    ) u_tmo (
        .i_clk     (pclk),
        .i_rst     (prst),
        .i_clear   (w_tmo_clear),
        .i_enable  (w_tmo_enable),
        .i_limit   (TMO_LIMIT),
        .o_expired (w_tmo_expired)
    );

    always_ff @(posedge pclk) begin
        if (prst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state          = r_state;
        csb2nvdla_ready       = 1'b0;
        psel                  = 1'b0;
        penable               = 1'b0;
        nvdla2csb_valid       = 1'b0;
        nvdla2csb_data        = '0;
        nvdla2csb_wr_complete = 1'b0;
        apb_err               = 1'b0;
        case (r_state)
            ST_IDLE: begin
                csb2nvdla_ready = 1'b1;
                if (csb2nvdla_valid) begin
                    w_next_state = ST_SETUP;
                end
            end
            ST_SETUP: begin
                psel         = 1'b1;
                w_next_state = ST_ACCESS;
            end
            ST_ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (pready || w_tmo_expired) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                nvdla2csb_valid       = !r_pwrite;
                nvdla2csb_data        = r_pwrite ? '0 : r_rdata;
                nvdla2csb_wr_complete = r_pwrite && r_nposted;
                apb_err               = r_err;
                w_next_state          = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Request fields are frozen at the handshake so APB signals hold through ACCESS.
    always_ff @(posedge pclk) begin
        if (prst) begin
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_pwrite  <= 1'b0;
            r_nposted <= 1'b0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
        end else if (w_handshake) begin
            r_paddr   <= csb_to_apb_addr(BASE_ADDR, csb2nvdla_addr);
            r_pwdata  <= csb2nvdla_write ? csb2nvdla_wdat : '0;
            r_pwrite  <= csb2nvdla_write;
            r_nposted <= csb2nvdla_nposted;
            r_rdata   <= '0;
            r_err     <= 1'b0;
        end else if (r_state == ST_ACCESS) begin
            if (pready) begin
                r_rdata <= pslverr ? ERR_RDATA : prdata;
                r_err   <= pslverr;
            end else if (w_tmo_expired) begin
                r_rdata <= TIMEOUT_RDATA;
                r_err   <= 1'b1;
            end
        end
    end

    assign paddr  = r_paddr;
    assign pwdata = r_pwdata;
    assign pwrite = r_pwrite;

endmodule

// File: tb/tb_nv_nvdla_csb2apb.sv
// Bench for nv_nvdla_csb2apb: table vectors, randomized transactions against a
// transaction-level model, and reset sequences.
module tb_nv_nvdla_csb2apb;

    localparam logic [31:0] BASE   = 32'h1000_0000;
    localparam logic [31:0] BASE_W = 32'hFFFF_FFF0;
    localparam int          TMO    = 4;

    logic        pclk = 1'b0;
    logic        prst = 1'b1;
    logic        csb2nvdla_valid = 1'b0;
    logic [15:0] csb2nvdla_addr = '0;
    logic [31:0] csb2nvdla_wdat = '0;
    logic        csb2nvdla_write = 1'b0;
    logic        csb2nvdla_nposted = 1'b0;
    logic [31:0] prdata = '0;
    logic        pready = 1'b0;
    logic        pslverr = 1'b0;

    logic        csb2nvdla_ready, nvdla2csb_valid, nvdla2csb_wr_complete;
    logic [31:0] nvdla2csb_data, paddr, pwdata;
    logic        psel, penable, pwrite, apb_err;

    logic        w_ready, w_valid, w_wrc, w_psel, w_penable, w_pwrite, w_err;
    logic [31:0] w_data, w_paddr, w_pwdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 pclk = ~pclk;

    nv_nvdla_csb2apb #(.BASE_ADDR(BASE), .TIMEOUT(TMO)) dut (
        .pclk(pclk), .prst(prst),
        .csb2nvdla_valid(csb2nvdla_valid), .csb2nvdla_ready(csb2nvdla_ready),
        .csb2nvdla_addr(csb2nvdla_addr), .csb2nvdla_wdat(csb2nvdla_wdat),
        .csb2nvdla_write(csb2nvdla_write), .csb2nvdla_nposted(csb2nvdla_nposted),
        .nvdla2csb_valid(nvdla2csb_valid), .nvdla2csb_data(nvdla2csb_data),
        .nvdla2csb_wr_complete(nvdla2csb_wr_complete),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr), .apb_err(apb_err)
    );

    // Second instance only differs in base address, exercising the 32-bit wrap.
    nv_nvdla_csb2apb #(.BASE_ADDR(BASE_W), .TIMEOUT(TMO)) dut_w (
        .pclk(pclk), .prst(prst),
        .csb2nvdla_valid(csb2nvdla_valid), .csb2nvdla_ready(w_ready),
        .csb2nvdla_addr(csb2nvdla_addr), .csb2nvdla_wdat(csb2nvdla_wdat),
        .csb2nvdla_write(csb2nvdla_write), .csb2nvdla_nposted(csb2nvdla_nposted),
        .nvdla2csb_valid(w_valid), .nvdla2csb_data(w_data),
        .nvdla2csb_wr_complete(w_wrc),
        .psel(w_psel), .penable(w_penable), .pwrite(w_pwrite), .paddr(w_paddr), .pwdata(w_pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr), .apb_err(w_err)
    );

    typedef struct {
        logic [15:0] addr;
        logic [31:0] wdat;
        logic        write;
        logic        nposted;
        int          waits;
        logic        slverr;
        logic [31:0] rdata;
        logic [31:0] e_paddr;
        logic [31:0] e_paddr_w;
        logic [31:0] e_pwdata;
        int          e_acc;
        int          e_vcnt;
        logic [31:0] e_data;
        int          e_wrc;
        int          e_err;
    } vec_t;

    typedef struct {
        logic        ready0;
        logic        setup_ok;
        logic [31:0] paddr;
        logic [31:0] paddr_w;
        logic [31:0] pwdata;
        logic        stable;
        logic        psel_bad;
        int          acc;
        int          vcnt;
        logic [31:0] data;
        int          wrc;
        int          err;
        int          resp_cyc;
        int          ready_cyc;
    } obs_t;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [15:0] a, input logic [31:0] wd, input logic wr,
                                 input logic np, input int w, input logic se, input logic [31:0] rd,
                                 input logic [31:0] ep, input logic [31:0] epw, input logic [31:0] epwd,
                                 input int eacc, input int ev, input logic [31:0] ed,
                                 input int ewc, input int ee);
        vec_t v;
        v.addr = a; v.wdat = wd; v.write = wr; v.nposted = np; v.waits = w;
        v.slverr = se; v.rdata = rd; v.e_paddr = ep; v.e_paddr_w = epw; v.e_pwdata = epwd;
        v.e_acc = eacc; v.e_vcnt = ev; v.e_data = ed; v.e_wrc = ewc; v.e_err = ee;
        return v;
    endfunction

    // Transaction-level expectation: what a single CSB request should look like on both sides.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        logic timed_out = (v.waits >= TMO);
        r.e_paddr   = BASE + 32'(v.addr) * 32'd4;
        r.e_paddr_w = BASE_W + 32'(v.addr) * 32'd4;
        r.e_pwdata  = v.write ? v.wdat : 32'h0;
        r.e_acc     = timed_out ? TMO : v.waits + 1;
        r.e_vcnt    = v.write ? 0 : 1;
        r.e_data    = v.write ? 32'h0 : (timed_out ? 32'hFFFF_FFFF : (v.slverr ? 32'h0 : v.rdata));
        r.e_wrc     = (v.write && v.nposted) ? 1 : 0;
        r.e_err     = (timed_out || v.slverr) ? 1 : 0;
        return r;
    endfunction

    task automatic run_txn(input vec_t v, output obs_t o);
        int acc = 0;
        o.psel_bad = 1'b0; o.vcnt = 0; o.data = '0; o.wrc = 0; o.err = 0;
        o.resp_cyc = -1; o.ready_cyc = -1;
        @(negedge pclk);
        o.ready0          = csb2nvdla_ready;
        csb2nvdla_valid   = 1'b1;
        csb2nvdla_addr    = v.addr;
        csb2nvdla_wdat    = v.wdat;
        csb2nvdla_write   = v.write;
        csb2nvdla_nposted = v.nposted;
        pready  = 1'($urandom);
        pslverr = 1'($urandom);
        prdata  = $urandom;
        @(negedge pclk);
        o.setup_ok = psel && !penable;
        o.paddr    = paddr;
        o.paddr_w  = w_paddr;
        o.pwdata   = pwdata;
        o.stable   = (pwrite == v.write);
        csb2nvdla_addr    = 16'($urandom);
        csb2nvdla_wdat    = $urandom;
        csb2nvdla_write   = 1'($urandom);
        csb2nvdla_nposted = 1'($urandom);
        pready  = 1'($urandom);
        pslverr = 1'($urandom);
        @(negedge pclk);
        for (int c = 2; c < 60 && o.ready_cyc < 0; c++) begin
            if (psel && penable) begin
                acc++;
                if (paddr !== o.paddr || pwdata !== o.pwdata || pwrite !== v.write ||
                    w_paddr !== o.paddr_w)
                    o.stable = 1'b0;
                pready          = (acc == v.waits + 1);
                pslverr         = pready ? v.slverr : 1'($urandom);
                prdata          = pready ? v.rdata : $urandom;
                csb2nvdla_valid = 1'($urandom);
            end else begin
                csb2nvdla_valid = 1'b0;
                if (psel) o.psel_bad = 1'b1;
                if (nvdla2csb_valid) begin
                    o.vcnt++;
                    o.data = nvdla2csb_data;
                end
                if (nvdla2csb_wr_complete) o.wrc++;
                if (apb_err) o.err++;
                if ((nvdla2csb_valid || nvdla2csb_wr_complete || apb_err) && o.resp_cyc < 0)
                    o.resp_cyc = c;
                if (csb2nvdla_ready) o.ready_cyc = c;
                pready  = 1'($urandom);
                pslverr = 1'($urandom);
                prdata  = $urandom;
            end
            if (o.ready_cyc < 0) @(negedge pclk);
        end
        o.acc = acc;
    endtask

    task automatic check_obs(input string tag, input vec_t v, input obs_t o);
        int any = v.e_vcnt + v.e_wrc + v.e_err;
        chk({tag, ".ready_idle"}, o.ready0, 1);
        chk({tag, ".setup"}, o.setup_ok, 1);
        chk({tag, ".paddr"}, o.paddr, v.e_paddr);
        chk({tag, ".paddr_wrap"}, o.paddr_w, v.e_paddr_w);
        chk({tag, ".pwdata"}, o.pwdata, v.e_pwdata);
        chk({tag, ".stable"}, o.stable, 1);
        chk({tag, ".psel_after"}, o.psel_bad, 0);
        chk({tag, ".access_cycles"}, o.acc, v.e_acc);
        chk({tag, ".rd_valid_cnt"}, o.vcnt, v.e_vcnt);
        chk({tag, ".rd_data"}, o.data, v.e_data);
        chk({tag, ".wr_complete_cnt"}, o.wrc, v.e_wrc);
        chk({tag, ".apb_err_cnt"}, o.err, v.e_err);
        chk({tag, ".resp_cycle"}, o.resp_cyc, (any > 0) ? 2 + v.e_acc : -1);
        chk({tag, ".ready_cycle"}, o.ready_cyc, 3 + v.e_acc);
    endtask

    function automatic logic [31:0] out_vec();
        return {psel, penable, pwrite, nvdla2csb_valid, nvdla2csb_wr_complete, apb_err} |
               paddr | pwdata | nvdla2csb_data;
    endfunction

    initial begin
        vec_t tbl[8];
        vec_t rv;
        obs_t o;
        int pulses;

        tbl[0] = mkv(16'h0010, 32'h0,         0, 0, 0, 0, 32'hCAFE_0001, 32'h1000_0040, 32'h0000_0030, 32'h0,         1, 1, 32'hCAFE_0001, 0, 0);
        tbl[1] = mkv(16'h0004, 32'h1234_5678, 1, 1, 3, 0, 32'h5555_5555, 32'h1000_0010, 32'h0000_0000, 32'h1234_5678, 4, 0, 32'h0,         1, 0);
        tbl[2] = mkv(16'h0100, 32'hA5A5_A5A5, 1, 0, 0, 0, 32'h0,         32'h1000_0400, 32'h0000_03F0, 32'hA5A5_A5A5, 1, 0, 32'h0,         0, 0);
        tbl[3] = mkv(16'h0020, 32'h7777_7777, 0, 0, 1, 1, 32'hDEAD_BEEF, 32'h1000_0080, 32'h0000_0070, 32'h0,         2, 1, 32'h0,         0, 1);
        tbl[4] = mkv(16'h0030, 32'h0,         0, 0, 9, 0, 32'h1111_2222, 32'h1000_00C0, 32'h0000_00B0, 32'h0,         4, 1, 32'hFFFF_FFFF, 0, 1);
        tbl[5] = mkv(16'hFFFF, 32'h0,         0, 0, 0, 0, 32'h0000_1111, 32'h1003_FFFC, 32'h0003_FFEC, 32'h0,         1, 1, 32'h0000_1111, 0, 0);
        tbl[6] = mkv(16'h0008, 32'h0F0F_0F0F, 1, 1, 2, 1, 32'h0,         32'h1000_0020, 32'h0000_0010, 32'h0F0F_0F0F, 3, 0, 32'h0,         1, 1);
        tbl[7] = mkv(16'h0002, 32'h0000_0001, 1, 0, 7, 0, 32'h0,         32'h1000_0008, 32'hFFFF_FFF8, 32'h0000_0001, 4, 0, 32'h0,         0, 1);

        // Reset state
        repeat (3) @(negedge pclk);
        chk("reset.outputs_zero", out_vec(), 0);
        chk("reset.ready", csb2nvdla_ready, 1);
        prst = 1'b0;
        @(negedge pclk);
        chk("reset.ready_after_release", csb2nvdla_ready, 1);

        for (int i = 0; i < 8; i++) begin
            run_txn(tbl[i], o);
            check_obs($sformatf("vec%0d", i), tbl[i], o);
        end

        for (int i = 0; i < 30; i++) begin
            rv.addr    = 16'($urandom);
            rv.wdat    = $urandom;
            rv.write   = 1'($urandom);
            rv.nposted = 1'($urandom);
            rv.waits   = int'($urandom_range(0, 6));
            rv.slverr  = ($urandom_range(0, 3) == 0);
            rv.rdata   = $urandom;
            rv = model(rv);
            run_txn(rv, o);
            check_obs($sformatf("rand%0d", i), rv, o);
        end

        // Reset in the middle of ACCESS: transfer abandoned, no response afterwards.
        @(negedge pclk);
        csb2nvdla_valid = 1'b1; csb2nvdla_addr = 16'h0055; csb2nvdla_write = 1'b0;
        pready = 1'b0;
        @(negedge pclk);
        csb2nvdla_valid = 1'b0;
        @(negedge pclk);
        chk("rst_access.in_access", psel && penable, 1);
        prst = 1'b1;
        @(negedge pclk);
        chk("rst_access.psel_dropped", psel, 0);
        chk("rst_access.outputs_zero", out_vec(), 0);
        chk("rst_access.ready_in_reset", csb2nvdla_ready, 1);
        prst = 1'b0;
        pready = 1'b1; pslverr = 1'b1; prdata = 32'h1357_9BDF;
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge pclk);
            if (nvdla2csb_valid || nvdla2csb_wr_complete || apb_err || psel) pulses++;
        end
        chk("rst_access.no_response", pulses, 0);
        chk("rst_access.ready_after", csb2nvdla_ready, 1);

        // Bridge still fully functional after the aborted transfer.
        run_txn(tbl[0], o);
        check_obs("post_reset", tbl[0], o);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
